// File: rtl/conv2_channel_accumulator.sv
// Time-shared channel accumulator for the conv stage 2 adder datapath.
// Sums NUM_CH signed partial sums per pixel and hands the result off with valid/ready.
module conv2_channel_accumulator #(
  parameter int NUM_CH = 6,
  parameter int IN_W   = 21,
  parameter int OUT_W  = 24,
  parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] ch_count,
  output logic [15:0]      pix_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] ch_q, ch_d;
  logic [15:0]      pix_q, pix_d;
  logic             ov_q, ov_d;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] sum;

  assign ext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign sum = acc_q + ext;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          ch_d    = '0;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = sum;
          ch_d  = ch_q + CNT_W'(1);
          if (ch_q == CNT_W'(NUM_CH - 1)) begin
            out_d   = sum;
            ov_d    = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // start only counts when it coincides with the output handshake
        if (out_ready) begin
          ov_d  = 1'b0;
          pix_d = pix_q + 16'd1;
          if (start) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            ch_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      out_q   <= '0;
      ch_q    <= '0;
      pix_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign out_data  = out_q;
  assign ch_count  = ch_q;
  assign pix_count = pix_q;

endmodule

// File: tb/tb_conv2_channel_accumulator.sv
// Directed bench for conv2_channel_accumulator.
// Linear sequence of steps with hand-computed expected sums.
module tb_conv2_channel_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [20:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_ready;
  logic        busy;
  logic [2:0]  ch_count;
  logic [15:0] pix_count;

  int checks = 0;
  int errors = 0;

  conv2_channel_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .ch_count  (ch_count),
    .pix_count (pix_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] s24(input int v);
    logic [31:0] t;
    t = v;
    return {8'h0, t[23:0]};
  endfunction

  function automatic logic [20:0] d21(input int v);
    logic [31:0] t;
    t = v;
    return t[20:0];
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = d21(v);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ch", 32'(ch_count), 32'd0);
    chk("rst_pix", 32'(pix_count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // idle ignores in_valid
    in_valid = 1'b1; in_data = d21(55);
    tick();
    in_valid = 1'b0;
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    // pixel 1: 1..6
    do_start();
    chk("p1_in_ready", 32'(in_ready), 32'd1);
    chk("p1_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = d21(i);
      tick();
      if (i == 5) chk("p1_no_early_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk("p1_out_valid", 32'(out_valid), 32'd1);
    chk("p1_out_data", 32'(out_data), s24(21));
    chk("p1_in_ready_hold", 32'(in_ready), 32'd0);
    chk("p1_ch6", 32'(ch_count), 32'd6);
    handshake();
    chk("p1_ov_clear", 32'(out_valid), 32'd0);
    chk("p1_pix", 32'(pix_count), 32'd1);
    chk("p1_ch_after", 32'(ch_count), 32'd6);
    chk("p1_idle", 32'(busy), 32'd0);
    chk("p1_data_kept", 32'(out_data), s24(21));

    // sign extremes
    do_start();
    feed(-1048576, 6);
    chk("neg_extreme", 32'(out_data), 32'h00A00000);
    handshake();
    do_start();
    feed(1048575, 6);
    chk("pos_extreme", 32'(out_data), s24(6291450));
    handshake();
    chk("pix3", 32'(pix_count), 32'd3);

    // gaps: 10..60 with two idle cycles between beats
    do_start();
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = d21(10 * i);
      tick();
      in_valid = 1'b0;
      if (i < 6) begin
        tick();
        tick();
        chk("gap_no_valid", 32'(out_valid), 32'd0);
      end
    end
    chk("gap_sum", 32'(out_data), s24(210));
    chk("gap_valid", 32'(out_valid), 32'd1);

    // backpressure with extra beats offered
    in_valid = 1'b1; in_data = d21(999);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), s24(210));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_pix", 32'(pix_count), 32'd4);
    chk("bp_idle", 32'(busy), 32'd0);

    // reset mid-pixel
    do_start();
    feed(100, 3);
    chk("mid_ch3", 32'(ch_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ch", 32'(ch_count), 32'd0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_pix", 32'(pix_count), 32'd0);
    do_start();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = d21(7);
      tick();
      if (i < 5) chk("mid_no_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk("mid_sum", 32'(out_data), s24(42));

    // back-to-back: handshake and start together
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    chk("b2b_ov", 32'(out_valid), 32'd0);
    chk("b2b_pix", 32'(pix_count), 32'd1);
    chk("b2b_ch0", 32'(ch_count), 32'd0);
    feed(-3, 3);

    // stray start during ACCUM
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stray_acc_ch", 32'(ch_count), 32'd3);
    chk("stray_acc_ready", 32'(in_ready), 32'd1);
    feed(-3, 3);
    chk("b2b_sum", 32'(out_data), s24(-18));
    chk("b2b_valid", 32'(out_valid), 32'd1);

    // stray start in HOLD without out_ready
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stray_hold_ov", 32'(out_valid), 32'd1);
    chk("stray_hold_ready", 32'(in_ready), 32'd0);
    chk("stray_hold_ch", 32'(ch_count), 32'd6);
    chk("stray_hold_data", 32'(out_data), s24(-18));
    handshake();
    chk("final_pix", 32'(pix_count), 32'd2);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2_channel_accumulator.md
# conv2_channel_accumulator

Sequencing controller for the convolution stage 2 adder datapath. It accepts one signed partial sum per input channel for a single output pixel and accumulates all NUM_CH values in a registered adder with sign extension. It then presents the pixel sum to the next stage under a valid/ready handshake. It sits between the per-channel adder-tree outputs and the bias/activation stage, replacing a fixed cascade of adder stages with one time-shared accumulator.

## Interface
- NUM_CH, 6: input channels summed per output pixel; legal range 2..64.
- IN_W, 21: width of each signed two's-complement partial sum.
- OUT_W, 24: accumulator and result width; must be ≥ IN_W + ceil(log2(NUM_CH)).
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a new pixel; sampled only in IDLE, or in HOLD together with out_ready.
- in_valid  input  1  in_data holds a valid partial sum.
- in_data  input  IN_W  signed partial sum for the current channel.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  out_data holds a completed pixel sum.
- out_data  output  OUT_W  signed sum of NUM_CH partial sums.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high in ACCUM and HOLD.
- ch_count  output  ceil(log2(NUM_CH+1))  beats accepted for the current pixel.
- pix_count  output  16  completed-pixel counter; wraps 0xFFFF→0.

## Operation
- Reset state after a clock edge with reset=1:
  - state=IDLE; acc, out_data, ch_count, and pix_count are 0.
  - in_ready, out_valid, and busy are 0.
  - reset overrides every other input in that cycle.
- IDLE:
  - in_ready=0.
  - start=1 → ACCUM; acc←0; ch_count←0.
  - in_valid is ignored.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid=1: acc←acc+sext(in_data) to OUT_W; ch_count increments.
  - in_valid=0 holds all state, with no timeout.
  - start is ignored.
  - On the accepted beat with ch_count==NUM_CH-1:
    - out_data←acc+sext(in_data);
    - out_valid←1; state→HOLD;
    - ch_count←NUM_CH.
- HOLD:
  - in_ready=0; out_valid=1.
  - out_data is held stable until handshake.
  - out_ready=1 → out_valid←0; pix_count increments.
  - With start=0 in that cycle, the next state is IDLE.
  - With start=1 in the same cycle, the next state is ACCUM, with acc←0 and ch_count←0.
  - start without out_ready is ignored.
- Arithmetic:
  - Signed throughout; every operand is sign-extended from bit IN_W-1.
  - No saturation or overflow flag; the width rule guarantees no overflow.
- out_data retains its last value after handshake until the next completion.
- in_ready and busy are decoded from the registered state only; no combinational path from any input.

## Timing
- One beat per cycle in ACCUM; minimum NUM_CH cycles of input per pixel.
- Latency: out_valid rises on the edge that accepts the last beat, so it is visible the cycle after that beat.
- Minimum pixel period: NUM_CH+1 cycles (ACCUM beats plus one HOLD cycle with out_ready=1 and start=1).
- From IDLE, the first beat can be accepted the cycle after start.
- Reset mid-ACCUM or mid-HOLD discards the partial or pending sum; no out_valid follows.

## Test plan
- Sum: reset, start, feed 1,2,3,4,5,6 back-to-back.
  - out_valid=1 the cycle after the 6th beat, with out_data=21.
  - ch_count=6 and pix_count=1 after out_ready.
- Sign extremes:
  - Six beats of -1048576 → out_data=-6291456 (0xA00000).
  - Six beats of 1048575 → 6291450.
- Gaps and backpressure:
  - in_valid toggles 1,0,0,1… across six beats → correct sum.
  - Hold out_ready=0 for 5 cycles: out_valid stays 1, out_data is stable, in_ready=0, and extra in_valid beats are not consumed.
- Reset mid-pixel: accept 3 beats (100,100,100), assert reset 1 cycle, then start and feed 6 beats of 7.
  - out_data=42; no earlier out_valid.
- Back-to-back pixels: in HOLD, assert out_ready=1 and start=1 together.
  - in_ready=1 the next cycle.
  - A second pixel of 6 beats of -3 yields -18.
  - pix_count=2.
- Stray start: start pulsed during ACCUM and in HOLD without out_ready → no change to acc, ch_count, or state.
